// File: rtl/mem_dumper_pkg.sv
// Shared definitions for the memory dumper and the CPU-side bus mux.
package mem_dumper_pkg;

    localparam int unsigned STATE_W = 3;

    // Encoding is fixed so the bus mux can decode the state directly.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/mem_dumper_if.sv
// Memory bus and output stream between the dumper, the memory and the sink.
interface mem_dumper_if #(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 8
);
    logic                  hold;
    logic                  bus_en;
    logic                  write;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [addr_width-1:0] out_addr;
    logic [data_width-1:0] out_data;
    logic                  out_last;

    modport master (
        output hold, bus_en, write, addr,
        output out_valid, out_addr, out_data, out_last,
        input  rdata, out_ready
    );

    modport slave (
        input  hold, bus_en, write, addr,
        input  out_valid, out_addr, out_data, out_last,
        output rdata, out_ready
    );
endinterface

// File: rtl/mem_dumper.sv
// Reads an inclusive, possibly wrapping address range from memory and streams
// each word out over valid/ready while holding the CPU off the bus.
module mem_dumper
    import mem_dumper_pkg::*;
#(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width-1:0] start_addr,
    input  logic [addr_width-1:0] end_addr,
    output logic                  busy,
    output logic                  done,
    mem_dumper_if.master          bus
);

    state_e                state_q, state_d;
    logic [addr_width-1:0] cur_q, cur_d;
    logic [addr_width-1:0] end_q, end_d;
    logic [addr_width-1:0] out_addr_q, out_addr_d;
    logic [data_width-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  hold_q, hold_d;
    logic                  bus_en_q, bus_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        end_d       = end_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        hold_d      = hold_q;
        bus_en_d    = bus_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d    = start_addr;
                    end_d    = end_addr;
                    hold_d   = 1'b1;
                    bus_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Address has been stable for two cycles, so both combinational
                // and one-cycle registered memories have valid data here.
                out_data_d  = bus.rdata;
                out_addr_d  = cur_q;
                out_last_d  = (cur_q == end_q);
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        hold_d   = 1'b0;
                        bus_en_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            end_q       <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            hold_q      <= 1'b0;
            bus_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            hold_q      <= hold_d;
            bus_en_q    <= bus_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.hold      = hold_q;
    assign bus.bus_en    = bus_en_q;
    assign bus.write     = 1'b0;
    assign bus.addr      = cur_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
